// File: rtl/truth_table_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : truth_table_sequencer
//  Description : Self-running exhaustive stimulus/capture stage for a
//                4-input, 2-output combinational block. On start it walks
//                {a,b,c,d} through 0..15, holds each vector for a
//                programmable dwell, and captures F1/F2 on the last dwell
//                cycle into two 16-bit response words.
//  Revision    : 1.0 - initial release
// ============================================================================
module truth_table_sequencer #(
    parameter int DWELL      = 10,   // dwell for vectors below TAIL_START (1..255)
    parameter int TAIL_DWELL = 50,   // dwell for vectors TAIL_START..15 (1..255)
    parameter int TAIL_START = 14    // first vector using TAIL_DWELL (0..16)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        f1_in,
    input  logic        f2_in,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic [3:0]  vec_idx,
    output logic        busy,
    output logic        done,
    output logic [15:0] resp_f1,
    output logic [15:0] resp_f2
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [7:0] DWELL_W      = 8'(DWELL);
    localparam logic [7:0] TAIL_DWELL_W = 8'(TAIL_DWELL);
    // Five bits so that TAIL_START = 16 ("no tail") is representable.
    localparam logic [4:0] TAIL_START_W = 5'(TAIL_START);

    state_t      state;
    logic [7:0]  dwell_cnt;
    logic [7:0]  dwell_limit;
    logic        last_cycle;

    // Dwell length for the vector currently on the outputs.
    assign dwell_limit = ({1'b0, vec_idx} < TAIL_START_W) ? DWELL_W : TAIL_DWELL_W;
    assign last_cycle  = (dwell_cnt == (dwell_limit - 8'd1));

    // Stimulus bits are direct copies of the vec_idx register bits, so each
    // vector change is glitch-free at the block boundary.
    assign {a, b, c, d} = vec_idx;

    // Sweep controller: sequencing, dwell counting and response capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            vec_idx   <= 4'd0;
            dwell_cnt <= 8'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            resp_f1   <= 16'd0;
            resp_f2   <= 16'd0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    // A restart from DONE behaves exactly like one from IDLE.
                    if (start) begin
                        state     <= ST_DRIVE;
                        vec_idx   <= 4'd0;
                        dwell_cnt <= 8'd0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        resp_f1   <= 16'd0;
                        resp_f2   <= 16'd0;
                    end
                end
                ST_DRIVE: begin
                    // start is deliberately ignored here.
                    if (last_cycle) begin
                        // Sample at the end of the dwell so the downstream
                        // block has had L-1 cycles to settle.
                        resp_f1[vec_idx] <= f1_in;
                        resp_f2[vec_idx] <= f2_in;
                        dwell_cnt        <= 8'd0;
                        if (vec_idx == 4'd15) begin
                            state   <= ST_DONE;
                            vec_idx <= 4'd0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            vec_idx <= vec_idx + 4'd1;
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
